clock_set_controller: RTL and testbench

Sequencer for the Basys3 12-hour clock. Generates the one-minute `enable_minute` tick for the hour/minute counter from the 100 MHz board clock and runs the RUN / SET_HOUR / SET_MIN mode machine. Conditions the raw buttons into single-cycle, auto-repeating increment pulses and drives digit-blink and colon controls for the seven-segment display driver. Sits between the board pins and the time counter.

---
 rtl/clock_pkg.sv | 11 +
 rtl/button_conditioner.sv | 49 ++++
 rtl/clock_set_controller.sv | 81 ++++++++
 tb/tb_clock_set_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding and display constants for the clock set controller
package clock_pkg;
   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2
   } mode_t;
   localparam int SECONDS_PER_MIN = 60;
   localparam logic [3:0] BLANK_HOURS = 4'b1100;
   localparam logic [3:0] BLANK_MINS  = 4'b0011;
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects a raw button, with optional auto-repeat
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 20_000_000,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic evt
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP = RW'(REPEAT_PERIOD - 1);
   logic s1, s2, prev, armed, first, press, rep;
   logic [DW-1:0] dcnt;
   logic [RW-1:0] rcnt;
   always_comb begin
      press = level & ~prev;
      rep = REPEAT_EN && armed && level && rcnt == (first ? RD : RP);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         level <= 1'b1;
         prev  <= 1'b1;
         dcnt  <= '0;
         armed <= 1'b0;
         first <= 1'b0;
         rcnt  <= '0;
         evt   <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         prev  <= level;
         evt   <= press | rep;
         dcnt  <= (s2 == level || dcnt == DMAX) ? '0 : dcnt + 1'b1;
         if (s2 != level && dcnt == DMAX) level <= s2;
         armed <= REPEAT_EN && (press || (armed && level));
         first <= press | (first & ~rep);
         rcnt  <= (press || rep || !armed) ? '0 : rcnt + 1'b1;
      end
   end
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: minute timebase, RUN/SET mode machine, increment pulses and blink/colon control
module clock_set_controller
   import clock_pkg::*;
#(
   parameter int CYCLES_PER_SEC  = 100_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 20_000_000,
   parameter int BLINK_HALF      = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnC,
   input  logic       btnL,
   input  logic       btnR,
   output logic       enable_minute,
   output logic       inc_hour,
   output logic       inc_min,
   output logic [1:0] mode,
   output logic [3:0] blank,
   output logic       colon
);
   localparam int PW = $clog2(CYCLES_PER_SEC);
   localparam int BW = $clog2(BLINK_HALF);
   localparam logic [PW-1:0] PMAX  = PW'(CYCLES_PER_SEC - 1);
   localparam logic [PW-1:0] PHALF = PW'(CYCLES_PER_SEC / 2);
   localparam logic [BW-1:0] BMAX  = BW'(BLINK_HALF - 1);
   localparam logic [5:0]    SMAX  = 6'(SECONDS_PER_MIN - 1);
   mode_t st, st_n;
   logic [PW-1:0] pres, pres_n;
   logic [5:0] sec, sec_n;
   logic [BW-1:0] bcnt, bcnt_n;
   logic phase, phase_n, run, tick, ih_n, im_n, hold, clr, bterm;
   logic c_evt, l_evt, r_evt, c_lvl, l_lvl, r_lvl;
   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)) u_c (.clk(clk), .reset(reset), .raw(btnC), .level(c_lvl), .evt(c_evt));
   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)) u_l (.clk(clk), .reset(reset), .raw(btnL), .level(l_lvl), .evt(l_evt));
   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)) u_r (.clk(clk), .reset(reset), .raw(btnR), .level(r_lvl), .evt(r_evt));
   assign mode = st;
   always_comb begin
      st_n = !c_evt ? st : st == MODE_RUN ? MODE_SET_HOUR : st == MODE_SET_HOUR ? MODE_SET_MIN : MODE_RUN;
      run = st == MODE_RUN && st_n == MODE_RUN;
      tick = run && pres == PMAX;
      pres_n = (!run || tick) ? '0 : pres + 1'b1;
      sec_n = !run ? '0 : !tick ? sec : sec == SMAX ? '0 : sec + 1'b1;
      ih_n = st == MODE_SET_HOUR && l_evt && !c_evt;
      im_n = st == MODE_SET_MIN && r_evt && !c_evt;
      hold = st_n == MODE_SET_HOUR ? l_lvl : st_n == MODE_SET_MIN ? r_lvl : c_lvl;
      clr = st_n == MODE_RUN || st_n != st || ih_n || im_n || hold;
      bterm = bcnt == BMAX;
      bcnt_n = (clr || bterm) ? '0 : bcnt + 1'b1;
      phase_n = !clr && (phase ^ bterm);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         st            <= MODE_RUN;
         pres          <= '0;
         sec           <= '0;
         bcnt          <= '0;
         phase         <= 1'b0;
         enable_minute <= 1'b0;
         inc_hour      <= 1'b0;
         inc_min       <= 1'b0;
         blank         <= 4'b0000;
         colon         <= 1'b1;
      end else begin
         st            <= st_n;
         pres          <= pres_n;
         sec           <= sec_n;
         bcnt          <= bcnt_n;
         phase         <= phase_n;
         enable_minute <= tick && sec == SMAX;
         inc_hour      <= ih_n;
         inc_min       <= im_n;
         blank         <= !phase_n ? 4'b0000 : st_n == MODE_SET_HOUR ? BLANK_HOURS : st_n == MODE_SET_MIN ? BLANK_MINS : 4'b0000;
         colon         <= st_n != MODE_RUN || pres_n < PHALF;
      end
   end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed self-checking bench for clock_set_controller with small parameters
module tb_clock_set_controller;
   logic clk = 1'b0, reset = 1'b1, btnC = 1'b0, btnL = 1'b0, btnR = 1'b0;
   logic enable_minute, inc_hour, inc_min, colon;
   logic [1:0] mode;
   logic [3:0] blank;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   clock_set_controller #(.CYCLES_PER_SEC(10), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20),
      .REPEAT_PERIOD(5), .BLINK_HALF(3)) dut (
      .clk(clk), .reset(reset), .btnC(btnC), .btnL(btnL), .btnR(btnR),
      .enable_minute(enable_minute), .inc_hour(inc_hour), .inc_min(inc_min),
      .mode(mode), .blank(blank), .colon(colon));
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask
   task automatic set_btn(input int which, input logic v);
      if (which == 0) btnC = v;
      else if (which == 1) btnL = v;
      else btnR = v;
   endtask
   task automatic pulse(input int which, output int pulses);
      pulses = 0;
      set_btn(which, 1'b1);
      for (int k = 0; k < 24; k++) begin
         cycle();
         if (k == 11) set_btn(which, 1'b0);
         pulses += int'(inc_hour) + int'(inc_min) + int'(enable_minute);
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) cycle();
      checks++;
      if ({mode, enable_minute, inc_hour, inc_min, blank, colon} !== 10'b00_0_0_0_0000_1) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", {mode, enable_minute, inc_hour, inc_min, blank, colon}, 10'b00_0_0_0_0000_1);
      end
      reset = 1'b0;
      for (int k = 1; k <= 1300; k++) begin
         cycle();
         checks++;
         if (enable_minute !== (k == 600 || k == 1200)) begin
            errors++;
            $display("FAIL run_enable_minute at cycle %0d: got %b expected %b", k, enable_minute, (k == 600 || k == 1200));
         end
         checks++;
         if (colon !== ((k % 10) < 5)) begin
            errors++;
            $display("FAIL run_colon at cycle %0d: got %b expected %b", k, colon, ((k % 10) < 5));
         end
      end
   endtask
   task automatic test_mode_bounce();
      logic [1:0] em;
      logic [3:0] eb;
      btnC = 1'b1;
      cycle();
      btnC = 1'b0;
      cycle();
      btnC = 1'b1;
      for (int k = 2; k <= 20; k++) begin
         cycle();
         em = (k >= 9) ? 2'd1 : 2'd0;
         eb = (k < 9) ? 4'b0000 : ((((k - 9) / 3) % 2) != 0) ? 4'b1100 : 4'b0000;
         checks++;
         if (mode !== em) begin
            errors++;
            $display("FAIL bounce_mode at cycle %0d: got %0d expected %0d", k, mode, em);
         end
         checks++;
         if (blank !== eb) begin
            errors++;
            $display("FAIL bounce_blank at cycle %0d: got %b expected %b", k, blank, eb);
         end
         if (k >= 9) begin
            checks++;
            if (colon !== 1'b1) begin
               errors++;
               $display("FAIL set_colon at cycle %0d: got %b expected 1", k, colon);
            end
         end
      end
      btnC = 1'b0;
      repeat (12) cycle();
      checks++;
      if (mode !== 2'd1) begin
         errors++;
         $display("FAIL bounce_single_advance: got %0d expected 1", mode);
      end
   endtask
   task automatic test_hour_repeat();
      logic ei;
      btnL = 1'b1;
      for (int k = 0; k <= 50; k++) begin
         cycle();
         if (k == 39) btnL = 1'b0;
         ei = k inside {7, 27, 32, 37, 42};
         checks++;
         if (inc_hour !== ei || inc_min !== 1'b0) begin
            errors++;
            $display("FAIL hour_repeat at cycle %0d: got inc_hour=%b inc_min=%b expected %b/0", k, inc_hour, inc_min, ei);
         end
         if (k >= 6) begin
            checks++;
            if (blank !== ((k >= 48) ? 4'b1100 : 4'b0000)) begin
               errors++;
               $display("FAIL hold_blank at cycle %0d: got %b expected %b", k, blank, ((k >= 48) ? 4'b1100 : 4'b0000));
            end
         end
      end
   endtask
   task automatic test_set_min();
      int p, tm, te;
      pulse(0, p);
      checks++;
      if (mode !== 2'd2 || p !== 0) begin
         errors++;
         $display("FAIL enter_set_min: got mode=%0d pulses=%0d expected 2/0", mode, p);
      end
      pulse(2, p);
      checks++;
      if (p !== 1) begin
         errors++;
         $display("FAIL set_min_btnR: got %0d pulses expected 1", p);
      end
      pulse(1, p);
      checks++;
      if (p !== 0) begin
         errors++;
         $display("FAIL set_min_btnL_ignored: got %0d pulses expected 0", p);
      end
      tm = -1;
      te = -1;
      btnC = 1'b1;
      for (int k = 0; k <= 700; k++) begin
         cycle();
         if (k == 11) btnC = 1'b0;
         if (tm < 0 && mode == 2'd0) tm = k;
         if (te < 0 && enable_minute === 1'b1) te = k;
      end
      checks++;
      if (tm !== 7) begin
         errors++;
         $display("FAIL return_run_cycle: got %0d expected 7", tm);
      end
      checks++;
      if (te !== 607) begin
         errors++;
         $display("FAIL first_minute_after_set: got %0d expected 607", te);
      end
   endtask
   task automatic test_collision();
      int p;
      pulse(0, p);
      pulse(0, p);
      checks++;
      if (mode !== 2'd2) begin
         errors++;
         $display("FAIL collision_setup_mode: got %0d expected 2", mode);
      end
      btnC = 1'b1;
      btnR = 1'b1;
      for (int k = 0; k <= 15; k++) begin
         cycle();
         if (k == 11) begin
            btnC = 1'b0;
            btnR = 1'b0;
         end
         checks++;
         if (inc_min !== 1'b0 || mode !== ((k >= 7) ? 2'd0 : 2'd2)) begin
            errors++;
            $display("FAIL collision at cycle %0d: got inc_min=%b mode=%0d expected 0/%0d", k, inc_min, mode, ((k >= 7) ? 0 : 2));
         end
      end
      repeat (12) cycle();
   endtask
   task automatic test_reset_held();
      int p, n;
      pulse(0, p);
      pulse(0, p);
      checks++;
      if (mode !== 2'd2) begin
         errors++;
         $display("FAIL held_setup_mode: got %0d expected 2", mode);
      end
      btnR = 1'b1;
      repeat (12) cycle();
      reset = 1'b1;
      cycle();
      checks++;
      if ({mode, enable_minute, inc_hour, inc_min, blank, colon} !== 10'b00_0_0_0_0000_1) begin
         errors++;
         $display("FAIL reset_mid_set: got %b expected %b", {mode, enable_minute, inc_hour, inc_min, blank, colon}, 10'b00_0_0_0_0000_1);
      end
      reset = 1'b0;
      repeat (10) cycle();
      pulse(0, p);
      n = p;
      pulse(0, p);
      n += p;
      for (int k = 0; k < 30; k++) begin
         cycle();
         n += int'(inc_min);
      end
      checks++;
      if (mode !== 2'd2 || n !== 0) begin
         errors++;
         $display("FAIL held_after_reset: got mode=%0d pulses=%0d expected 2/0", mode, n);
      end
      btnR = 1'b0;
      repeat (12) cycle();
      pulse(2, p);
      checks++;
      if (p !== 1) begin
         errors++;
         $display("FAIL repress_after_reset: got %0d pulses expected 1", p);
      end
   endtask
   initial begin
      test_reset();
      test_mode_bounce();
      test_hour_repeat();
      test_set_min();
      test_collision();
      test_reset_held();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
